// File: rtl/mem_line_ctrl.sv
// Cache line transfer controller: moves one line between a cache-side line
// buffer and a word-wide main memory. Supports fill, writeback and
// writeback-then-fill, one word per memory handshake with a one-cycle gap
// between words.
module mem_line_ctrl #(
    parameter int BURST_WIDTH = 8,
    parameter int LG          = $clog2(BURST_WIDTH)
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      REQ_VALID,
    output logic                      REQ_READY,
    input  logic [1:0]                REQ_OP,
    input  logic [31:0]               REQ_WB_ADDR,
    input  logic [31:0]               REQ_FILL_ADDR,
    input  logic [32*BURST_WIDTH-1:0] WB_LINE,
    output logic [32*BURST_WIDTH-1:0] FILL_LINE,
    output logic                      DONE,
    output logic                      MEM_RE,
    output logic                      MEM_WE,
    output logic [29:0]               MEM_ADDR,
    output logic [31:0]               MEM_DATA_IN,
    input  logic [31:0]               MEM_DOUT,
    input  logic                      memValid
);

    // Width of the line base address (word address minus the word index).
    localparam int BW = 30 - LG;
    localparam logic [LG-1:0] IDX_LAST = LG'(BURST_WIDTH - 1);
    localparam logic [LG-1:0] IDX_ONE  = LG'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WB_REQ = 3'd1,
        WB_GAP = 3'd2,
        RD_REQ = 3'd3,
        RD_GAP = 3'd4,
        FIN    = 3'd5
    } state_t;

    state_t                    state_r, state_s;
    logic [LG-1:0]             idx_r, idx_s;
    logic [1:0]                op_r, op_s;
    logic [BW-1:0]             wb_base_r, wb_base_s;
    logic [BW-1:0]             fill_base_r, fill_base_s;
    logic [32*BURST_WIDTH-1:0] wb_line_r, wb_line_s;
    logic [32*BURST_WIDTH-1:0] fill_line_r;
    logic [31:0]               wb_word_s;
    logic                      done_r;
    logic                      mem_re_r;
    logic                      mem_we_r;
    logic [29:0]               mem_addr_r;
    logic [31:0]               mem_data_r;

    assign REQ_READY   = (state_r == IDLE);
    assign FILL_LINE   = fill_line_r;
    assign DONE        = done_r;
    assign MEM_RE      = mem_re_r;
    assign MEM_WE      = mem_we_r;
    assign MEM_ADDR    = mem_addr_r;
    assign MEM_DATA_IN = mem_data_r;

    // Next-state, next-index and request capture; memory outputs are then
    // registered from these next values so they line up with the new state.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        op_s        = op_r;
        wb_base_s   = wb_base_r;
        fill_base_s = fill_base_r;
        wb_line_s   = wb_line_r;
        case (state_r)
            IDLE: begin
                if (REQ_VALID) begin
                    op_s        = REQ_OP;
                    wb_base_s   = REQ_WB_ADDR[31:LG+2];
                    fill_base_s = REQ_FILL_ADDR[31:LG+2];
                    wb_line_s   = WB_LINE;
                    idx_s       = '0;
                    case (REQ_OP)
                        2'b00:   state_s = FIN;
                        2'b01:   state_s = RD_REQ;
                        default: state_s = WB_REQ;
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            WB_REQ: begin
                if (memValid) begin
                    state_s = WB_GAP;
                end else begin
                    state_s = WB_REQ;
                end
            end
            WB_GAP: begin
                if (idx_r != IDX_LAST) begin
                    idx_s   = idx_r + IDX_ONE;
                    state_s = WB_REQ;
                end else if (op_r == 2'b11) begin
                    idx_s   = '0;
                    state_s = RD_REQ;
                end else begin
                    state_s = FIN;
                end
            end
            RD_REQ: begin
                if (memValid) begin
                    state_s = RD_GAP;
                end else begin
                    state_s = RD_REQ;
                end
            end
            RD_GAP: begin
                if (idx_r != IDX_LAST) begin
                    idx_s   = idx_r + IDX_ONE;
                    state_s = RD_REQ;
                end else begin
                    state_s = FIN;
                end
            end
            FIN:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
        wb_word_s = wb_line_s[{idx_s, 5'b00000} +: 32];
    end

    // Controller state, operation context and the DONE pulse.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            op_r        <= 2'b00;
            wb_base_r   <= '0;
            fill_base_r <= '0;
            wb_line_r   <= '0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            op_r        <= op_s;
            wb_base_r   <= wb_base_s;
            fill_base_r <= fill_base_s;
            wb_line_r   <= wb_line_s;
            done_r      <= (state_s == FIN);
        end
    end

    // Memory request outputs: strobes only in request states, address/data
    // held from the request entry until the handshake completes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            mem_re_r   <= 1'b0;
            mem_we_r   <= 1'b0;
            mem_addr_r <= 30'd0;
            mem_data_r <= 32'd0;
        end else begin
            mem_we_r <= (state_s == WB_REQ);
            mem_re_r <= (state_s == RD_REQ);
            if (state_s == WB_REQ) begin
                mem_addr_r <= {wb_base_s, idx_s};
                mem_data_r <= wb_word_s;
            end else if (state_s == RD_REQ) begin
                mem_addr_r <= {fill_base_s, idx_s};
            end else begin
                mem_addr_r <= mem_addr_r;
            end
        end
    end

    // Fill line capture: only a completed read handshake writes a word.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fill_line_r <= '0;
        end else if ((state_r == RD_REQ) && memValid) begin
            fill_line_r[{idx_r, 5'b00000} +: 32] <= MEM_DOUT;
        end else begin
            fill_line_r <= fill_line_r;
        end
    end

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Directed self-checking bench for mem_line_ctrl with a latency-programmable
// memory responder and a transfer log.
module tb_mem_line_ctrl;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         REQ_VALID = 1'b0;
    logic         REQ_READY;
    logic [1:0]   REQ_OP = 2'b00;
    logic [31:0]  REQ_WB_ADDR = 32'd0;
    logic [31:0]  REQ_FILL_ADDR = 32'd0;
    logic [255:0] WB_LINE = 256'd0;
    logic [255:0] FILL_LINE;
    logic         DONE;
    logic         MEM_RE;
    logic         MEM_WE;
    logic [29:0]  MEM_ADDR;
    logic [31:0]  MEM_DATA_IN;
    logic [31:0]  MEM_DOUT = 32'd0;
    logic         memValid = 1'b0;

    int tests_run = 0;
    int fails = 0;

    logic [31:0] mem [0:511];
    int          lat = 10;
    bit          stray = 1'b0;
    int          wait_cnt = 0;
    int          done_cnt = 0;
    bit          both_high = 1'b0;
    bit          re_seen = 1'b0;
    bit          we_seen = 1'b0;
    logic [29:0] ev_addr_q[$];
    logic [31:0] ev_data_q[$];
    bit          ev_wr_q[$];

    mem_line_ctrl #(.BURST_WIDTH(8)) dut (
        .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_OP(REQ_OP), .REQ_WB_ADDR(REQ_WB_ADDR), .REQ_FILL_ADDR(REQ_FILL_ADDR),
        .WB_LINE(WB_LINE), .FILL_LINE(FILL_LINE), .DONE(DONE),
        .MEM_RE(MEM_RE), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_DATA_IN(MEM_DATA_IN), .MEM_DOUT(MEM_DOUT), .memValid(memValid)
    );

    always #5 CLK = ~CLK;

    initial begin
        for (int a = 0; a < 512; a++) mem[a] = 32'hA000_0000 + a;
    end

    // Memory responder and monitor, evaluated on the falling edge.
    always @(negedge CLK) begin
        if (MEM_RE && MEM_WE) both_high = 1'b1;
        if (MEM_RE) re_seen = 1'b1;
        if (MEM_WE) we_seen = 1'b1;
        if (DONE) done_cnt++;
        if (MEM_RE || MEM_WE) begin
            if (wait_cnt >= lat - 1) begin
                memValid = 1'b1;
                wait_cnt = 0;
                ev_addr_q.push_back(MEM_ADDR);
                ev_wr_q.push_back(MEM_WE);
                ev_data_q.push_back(MEM_DATA_IN);
                if (MEM_WE) mem[MEM_ADDR[8:0]] = MEM_DATA_IN;
                else MEM_DOUT = mem[MEM_ADDR[8:0]];
            end else begin
                memValid = 1'b0;
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
            if (stray) begin
                memValid = 1'b1;
                MEM_DOUT = 32'hDEAD_BEEF;
            end else begin
                memValid = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        ev_addr_q = {};
        ev_data_q = {};
        ev_wr_q = {};
        done_cnt = 0;
        re_seen = 1'b0;
        we_seen = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] wb, input logic [31:0] fill,
                         input logic [31:0] wbase);
        @(negedge CLK);
        REQ_OP = op;
        REQ_WB_ADDR = wb;
        REQ_FILL_ADDR = fill;
        for (int i = 0; i < 8; i++) WB_LINE[32*i +: 32] = wbase + i;
        REQ_VALID = 1'b1;
        @(negedge CLK);
        REQ_VALID = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        while (!DONE && k < budget) begin
            @(negedge CLK);
            k++;
        end
        tests_run++;
        if (DONE !== 1'b1) begin
            fails++;
            $display("FAIL %s_done_timeout: DONE=%b after %0d cycles, required 1", name, DONE, k);
        end
        @(negedge CLK);
        @(negedge CLK);
    endtask

    task automatic check_fill(input string name, input logic [31:0] base);
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (FILL_LINE[32*i +: 32] !== base + i) begin
                fails++;
                $display("FAIL %s_word%0d: got %h, required %h", name, i, FILL_LINE[32*i +: 32], base + i);
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        tests_run++;
        if ({REQ_READY, MEM_RE, MEM_WE, DONE} !== 4'b1000 || FILL_LINE !== 256'd0 || MEM_ADDR !== 30'd0) begin
            fails++;
            $display("FAIL reset_state: rdy/re/we/done=%b addr=%h fill=%h, required 1000 0 0",
                     {REQ_READY, MEM_RE, MEM_WE, DONE}, MEM_ADDR, FILL_LINE);
        end
    endtask

    task automatic test_fill();
        lat = 10;
        clear_log();
        issue(2'b01, 32'h0, 32'h0000_0100, 32'h0);
        wait_done(2000, "fill");
        tests_run++;
        if (ev_addr_q.size() != 8 || done_cnt != 1 || we_seen) begin
            fails++;
            $display("FAIL fill_shape: reads=%0d dones=%0d we_seen=%b, required 8 1 0",
                     ev_addr_q.size(), done_cnt, we_seen);
        end
        for (int i = 0; i < ev_addr_q.size() && i < 8; i++) begin
            tests_run++;
            if (ev_addr_q[i] !== 30'h40 + i || ev_wr_q[i] !== 1'b0) begin
                fails++;
                $display("FAIL fill_addr%0d: got %h wr=%b, required %h wr=0", i, ev_addr_q[i], ev_wr_q[i], 30'h40 + i);
            end
        end
        check_fill("fill_data", 32'hA000_0040);
    endtask

    task automatic test_writeback();
        clear_log();
        issue(2'b10, 32'h0000_0200, 32'h0000_0500, 32'h1111_0000);
        wait_done(2000, "wb");
        tests_run++;
        if (ev_addr_q.size() != 8 || done_cnt != 1 || re_seen) begin
            fails++;
            $display("FAIL wb_shape: writes=%0d dones=%0d re_seen=%b, required 8 1 0",
                     ev_addr_q.size(), done_cnt, re_seen);
        end
        for (int i = 0; i < ev_addr_q.size() && i < 8; i++) begin
            tests_run++;
            if (ev_addr_q[i] !== 30'h80 + i || ev_data_q[i] !== 32'h1111_0000 + i || ev_wr_q[i] !== 1'b1) begin
                fails++;
                $display("FAIL wb_word%0d: addr %h data %h, required %h %h", i, ev_addr_q[i], ev_data_q[i],
                         30'h80 + i, 32'h1111_0000 + i);
            end
        end
        check_fill("wb_fill_held", 32'hA000_0040);
    endtask

    task automatic test_wb_fill();
        lat = 4;
        clear_log();
        issue(2'b11, 32'h0000_0300, 32'h0000_0400, 32'h2222_0000);
        wait_done(2000, "wbfill");
        tests_run++;
        if (ev_addr_q.size() != 16 || done_cnt != 1) begin
            fails++;
            $display("FAIL wbfill_shape: transfers=%0d dones=%0d, required 16 1", ev_addr_q.size(), done_cnt);
        end
        for (int i = 0; i < ev_addr_q.size() && i < 16; i++) begin
            tests_run++;
            if (i < 8 && (ev_wr_q[i] !== 1'b1 || ev_addr_q[i] !== 30'hC0 + i || ev_data_q[i] !== 32'h2222_0000 + i)) begin
                fails++;
                $display("FAIL wbfill_wr%0d: wr=%b addr=%h data=%h, required 1 %h %h", i, ev_wr_q[i],
                         ev_addr_q[i], ev_data_q[i], 30'hC0 + i, 32'h2222_0000 + i);
            end else if (i >= 8 && (ev_wr_q[i] !== 1'b0 || ev_addr_q[i] !== 30'h100 + (i - 8))) begin
                fails++;
                $display("FAIL wbfill_rd%0d: wr=%b addr=%h, required 0 %h", i - 8, ev_wr_q[i],
                         ev_addr_q[i], 30'h100 + (i - 8));
            end
        end
        check_fill("wbfill_data", 32'hA000_0100);
        clear_log();
        issue(2'b01, 32'h0, 32'h0000_0300, 32'h0);
        wait_done(2000, "readback");
        check_fill("readback", 32'h2222_0000);
    endtask

    task automatic test_reset_mid();
        int k = 0;
        lat = 10;
        clear_log();
        issue(2'b01, 32'h0, 32'h0000_0100, 32'h0);
        while (!(MEM_RE && MEM_ADDR == 30'h43) && k < 500) begin
            @(negedge CLK);
            k++;
        end
        tests_run++;
        if (!(MEM_RE && MEM_ADDR == 30'h43)) begin
            fails++;
            $display("FAIL rstmid_reach: re=%b addr=%h, required 1 043", MEM_RE, MEM_ADDR);
        end
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        tests_run++;
        if (REQ_READY !== 1'b1 || MEM_RE !== 1'b0 || FILL_LINE !== 256'd0 || DONE !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_state: rdy=%b re=%b done=%b fill=%h, required 1 0 0 0",
                     REQ_READY, MEM_RE, DONE, FILL_LINE);
        end
        repeat (4) @(negedge CLK);
        tests_run++;
        if (done_cnt != 0 || REQ_READY !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_nodone: dones=%0d rdy=%b, required 0 1", done_cnt, REQ_READY);
        end
    endtask

    task automatic test_align_stray();
        lat = 3;
        stray = 1'b1;
        clear_log();
        repeat (3) @(negedge CLK);
        tests_run++;
        if (REQ_READY !== 1'b1 || MEM_RE !== 1'b0 || FILL_LINE !== 256'd0) begin
            fails++;
            $display("FAIL stray_idle: rdy=%b re=%b fill=%h, required 1 0 0", REQ_READY, MEM_RE, FILL_LINE);
        end
        issue(2'b01, 32'h0, 32'h0000_011C, 32'h0);
        wait_done(2000, "align");
        stray = 1'b0;
        tests_run++;
        if (ev_addr_q.size() != 8 || done_cnt != 1) begin
            fails++;
            $display("FAIL align_shape: reads=%0d dones=%0d, required 8 1", ev_addr_q.size(), done_cnt);
        end
        for (int i = 0; i < ev_addr_q.size() && i < 8; i++) begin
            tests_run++;
            if (ev_addr_q[i] !== 30'h40 + i) begin
                fails++;
                $display("FAIL align_addr%0d: got %h, required %h", i, ev_addr_q[i], 30'h40 + i);
            end
        end
        check_fill("align_data", 32'hA000_0040);
    endtask

    task automatic test_back_to_back();
        lat = 2;
        clear_log();
        @(negedge CLK);
        REQ_OP = 2'b00;
        REQ_VALID = 1'b1;
        @(posedge CLK);
        #1;
        REQ_OP = 2'b01;
        REQ_FILL_ADDR = 32'h0000_0100;
        @(negedge CLK);
        tests_run++;
        if (DONE !== 1'b1 || REQ_READY !== 1'b0) begin
            fails++;
            $display("FAIL b2b_fin: done=%b rdy=%b, required 1 0", DONE, REQ_READY);
        end
        @(negedge CLK);
        tests_run++;
        if (DONE !== 1'b0 || REQ_READY !== 1'b1) begin
            fails++;
            $display("FAIL b2b_idle: done=%b rdy=%b, required 0 1", DONE, REQ_READY);
        end
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        @(negedge CLK);
        tests_run++;
        if (MEM_RE !== 1'b1 || MEM_ADDR !== 30'h40) begin
            fails++;
            $display("FAIL b2b_second: re=%b addr=%h, required 1 040", MEM_RE, MEM_ADDR);
        end
        wait_done(2000, "b2b");
        tests_run++;
        if (done_cnt != 2 || both_high) begin
            fails++;
            $display("FAIL b2b_end: dones=%0d both_high=%b, required 2 0", done_cnt, both_high);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_writeback();
        test_wb_fill();
        test_reset_mid();
        test_align_stray();
        test_back_to_back();
        tests_run++;
        if (both_high) begin
            fails++;
            $display("FAIL re_we_exclusive: both_high=%b, required 0", both_high);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/mem_line_ctrl.md
MEM_LINE_CTRL -- requirements
Module: mem_line_ctrl

Interface
REQ-001 SHALL have parameter BURST_WIDTH, default 8, giving words per cache line (power of two, 2..64).
REQ-002 SHALL have parameter LG, default $clog2(BURST_WIDTH), giving the word-index width.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port REQ_VALID  input  1  cache side presents a line operation.
REQ-006 SHALL have port REQ_READY  output  1  controller can accept an operation.
REQ-007 SHALL have port REQ_OP  input  2  operation code: 00 none, 01 fill, 10 writeback, 11 writeback-then-fill.
REQ-008 SHALL have port REQ_WB_ADDR  input  32  byte address of the line to write back.
REQ-009 SHALL have port REQ_FILL_ADDR  input  32  byte address of the line to fill.
REQ-010 SHALL have port WB_LINE  input  32*BURST_WIDTH  writeback data; word i is bits [32i+31:32i].
REQ-011 SHALL have port FILL_LINE  output  32*BURST_WIDTH  fill data, same word packing.
REQ-012 SHALL have port DONE  output  1  one-cycle pulse when the operation completes.
REQ-013 SHALL have port MEM_RE  output  1  read request to main memory.
REQ-014 SHALL have port MEM_WE  output  1  write request to main memory.
REQ-015 SHALL have port MEM_ADDR  output  30  word address to memory (byte address [31:2]).
REQ-016 SHALL have port MEM_DATA_IN  output  32  write data to memory.
REQ-017 SHALL have port MEM_DOUT  input  32  read data from memory.
REQ-018 SHALL have port memValid  input  1  memory completion strobe for the current word.

Function
REQ-019 SHALL implement states IDLE, WB_REQ, WB_GAP, RD_REQ, RD_GAP, FIN.
REQ-020 SHALL drive REQ_READY=1 only in IDLE, combinationally.
REQ-021 SHALL accept on the rising edge where REQ_VALID&REQ_READY and register REQ_OP, both addresses and WB_LINE at that edge.
REQ-022 SHALL ignore address bits [LG+1:0]; line base = addr[31:LG+2].
REQ-023 SHALL transition on accept: op 00 -> FIN; 01 -> RD_REQ; 10 and 11 -> WB_REQ; word index cleared to 0.
REQ-024 SHALL in WB_REQ register MEM_WE=1, MEM_RE=0, MEM_ADDR={wb_base,idx}, MEM_DATA_IN=word idx, all held stable until memValid is sampled high.
REQ-025 SHALL in RD_REQ register MEM_RE=1, MEM_WE=0, MEM_ADDR={fill_base,idx}, held stable until memValid is sampled high.
REQ-026 SHALL on a rising edge in RD_REQ with memValid=1 capture MEM_DOUT into FILL_LINE word idx.
REQ-027 SHALL on memValid=1 in a *_REQ state move to the matching *_GAP state for exactly one cycle with MEM_RE=MEM_WE=0.
REQ-028 SHALL leave a GAP state by: idx<BURST_WIDTH-1 -> idx+1, back to same *_REQ; idx==BURST_WIDTH-1 -> WB_GAP goes to RD_REQ (op 11, idx=0) or FIN (op 10); RD_GAP goes to FIN.
REQ-029 SHALL never assert MEM_RE and MEM_WE together; neither is asserted outside *_REQ states.
REQ-030 SHALL ignore memValid in IDLE, GAP and FIN states.
REQ-031 SHALL assert DONE=1 for exactly the one cycle in FIN, then return to IDLE.
REQ-032 SHALL update FILL_LINE only in RD_REQ; value held otherwise, including across writeback-only ops.
REQ-033 SHALL wait indefinitely for memValid (no timeout).
REQ-034 SHALL take per word (request cycles until memValid)+1 gap cycle; op 00 completes with DONE one cycle after accept.
REQ-035 SHALL accept a new request held on REQ_VALID in the first IDLE cycle after FIN (one cycle gap minimum).

Reset
REQ-036 SHALL on RESET=1 at a rising edge enter IDLE and clear idx, DONE, MEM_RE, MEM_WE, MEM_ADDR, MEM_DATA_IN, FILL_LINE to 0, regardless of state.
REQ-037 SHALL on reset mid-operation abandon it with no DONE; REQ_READY=1 the cycle after reset is released.
REQ-038 SHALL give RESET priority over REQ_VALID and memValid in the same cycle.

Verification
REQ-039 Fill: op 01, REQ_FILL_ADDR=0x0000_0100, memory word a = 0xA000_0000+a, responder latency 10 -> MEM_ADDR 0x40..0x47 in order, FILL_LINE word i = 0xA000_0040+i, one DONE, MEM_WE never high.
REQ-040 Writeback: op 10, REQ_WB_ADDR=0x0000_0200, WB_LINE word i=0x1111_0000+i -> 8 writes at MEM_ADDR 0x80..0x87 with matching data, MEM_RE never high, FILL_LINE unchanged.
REQ-041 Writeback-then-fill: op 11, wb 0x300, fill 0x400 -> all 8 writes (0xC0..0xC7) complete before first MEM_RE (0x100); readback of 0x300 line returns written data.
REQ-042 Reset during fill word 3 -> next cycle IDLE, MEM_RE=0, FILL_LINE=0, REQ_READY=1, no DONE pulse.
REQ-043 Alignment and strays: REQ_FILL_ADDR=0x0000_011C -> addresses 0x40..0x47; memValid forced high in GAP/IDLE -> no capture, no index advance.
REQ-044 Back-to-back: REQ_VALID held high with op 00 then op 01 -> DONE one cycle after first accept, second accepted in following IDLE cycle, MEM_RE/MEM_WE never high together.
